operand_sequencer: RTL

OPERAND_SEQUENCER -- requirements
Module: operand_sequencer

---
 rtl/operand_sequencer.sv | 100 ++++++++++
 1 files changed

// File: rtl/operand_sequencer.sv
// operand_sequencer: operand-triple FIFO feeding a replay/LFSR issue sequencer
module operand_sequencer #(
    parameter int          DEPTH = 4,
    parameter logic [31:0] SEED  = 32'h0000_00C8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic [31:0] in_c,
    input  logic        start,
    input  logic        mode,
    input  logic [7:0]  count,
    output logic [31:0] a,
    output logic [31:0] b,
    output logic [31:0] c,
    output logic        out_valid,
    output logic        busy,
    output logic        done
);
    localparam int          AW       = $clog2(DEPTH);
    localparam logic [31:0] SEED_EFF = (SEED == 32'd0) ? 32'd1 : SEED;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t        state;
    logic [95:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   occ;
    logic          mode_q;
    logic [7:0]    remaining;
    logic [31:0]   lfsr, lfsr_next;
    logic [31:0]   ia, ib, ic;
    logic          push, pop, issue;
    assign in_ready  = occ != (AW+1)'(DEPTH);
    assign push      = in_valid && in_ready;
    // pop uses registered occupancy, so a triple pushed into an empty FIFO waits a cycle
    assign pop       = state == RUN && !mode_q && occ != '0;
    assign issue     = state == RUN && (mode_q || occ != '0);
    assign lfsr_next = lfsr[0] ? (lfsr >> 1) ^ 32'h8020_0003 : lfsr >> 1;
    assign ia        = mode_q ? lfsr_next : mem[rd_ptr][95:64];
    assign ib        = mode_q ? {lfsr_next[15:0], lfsr_next[31:16]} : mem[rd_ptr][63:32];
    assign ic        = mode_q ? ~lfsr_next : mem[rd_ptr][31:0];
    always_ff @(posedge clk) begin
        if (push && !rst)
            mem[wr_ptr] <= {in_a, in_b, in_c};
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occ       <= '0;
            mode_q    <= 1'b0;
            remaining <= '0;
            lfsr      <= SEED_EFF;
            a         <= '0;
            b         <= '0;
            c         <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            occ       <= occ + (AW+1)'(push) - (AW+1)'(pop);
            out_valid <= issue;
            done      <= 1'b0;
            if (issue) begin
                a         <= ia;
                b         <= ib;
                c         <= ic;
                remaining <= remaining - 8'd1;
                if (mode_q)
                    lfsr <= lfsr_next;
            end
            case (state)
                IDLE: if (start) begin
                    if (count != 8'd0) begin
                        mode_q    <= mode;
                        remaining <= count;
                        state     <= RUN;
                        busy      <= 1'b1;
                    end else begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                RUN: if (issue && remaining == 8'd1) begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
